// File: rtl/spi_master_tx_if.sv
// FIFO read port, enable/status and SPI pins of spi_master_tx bundled as one interface.
// master = transmitter side, slave = the FIFO/controller/SPI peer side.
interface spi_master_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              enable;
   logic              rd_empty;
   logic [DATA_W-1:0] rd_data;
   logic              rd_en;
   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic              busy;
   logic              done;

   modport master (
      input  enable, rd_empty, rd_data,
      output rd_en, sclk, cs_n, mosi, busy, done
   );

   modport slave (
      output enable, rd_empty, rd_data,
      input  rd_en, sclk, cs_n, mosi, busy, done
   );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmitter: pops words from a TX FIFO and shifts them out MSB-first.
// Optional SPI_MASTER_TX_BURST_EN keeps cs_n low and chains words back-to-back.
module spi_master_tx #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned IDLE_GAP = 2
) (
   input  logic            rd_clk,
   input  logic            rd_rst_n,
   spi_master_tx_if.master bus
);

   localparam int unsigned M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned M2      = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
   localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((CS_SETUP > 1) ? (CS_SETUP - 2) : 0);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(IDLE_GAP - 1);
   localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              rd_en_q, rd_en_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SPI_MASTER_TX_BURST_EN
   logic [1:0]        ld_q, ld_d;
`endif

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         rd_en_q <= 1'b0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_MASTER_TX_BURST_EN
         ld_q    <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         rd_en_q <= rd_en_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SPI_MASTER_TX_BURST_EN
         ld_q    <= ld_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      rd_en_d = 1'b0;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
`ifdef SPI_MASTER_TX_BURST_EN
      ld_d    = ld_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.enable && !bus.rd_empty) begin
               rd_en_d = 1'b1;
               state_d = S_FETCH;
               cnt_d   = CNT_W'(1);
            end
         end
         // First cycle: pop in flight, drop cs_n. Second cycle: FIFO data is valid.
         S_FETCH: begin
            if (cnt_q != '0) begin
               cnt_d  = cnt_q - CNT_W'(1);
               cs_n_d = 1'b0;
            end else begin
               shreg_d = bus.rd_data;
               mosi_d  = bus.rd_data[DATA_W-1];
               if (CS_SETUP > 1) begin
                  state_d = S_SETUP;
                  cnt_d   = SETUP_LD;
               end else begin
                  state_d = S_SHIFT;
                  cnt_d   = DIV_LD;
                  bit_d   = BIT_LD;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_SHIFT;
               cnt_d   = DIV_LD;
               bit_d   = BIT_LD;
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!sclk_q) begin
               sclk_d = 1'b1;
               cnt_d  = DIV_LD;
            end else begin
               sclk_d = 1'b0;
               cnt_d  = DIV_LD;
               if (bit_q != '0) begin
                  bit_d   = bit_q - BIT_W'(1);
                  shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                  mosi_d  = shreg_q[DATA_W-2];
               end else begin
`ifdef SPI_MASTER_TX_BURST_EN
                  // Chain the next word into the low phase that starts right now.
                  if (bus.enable && !bus.rd_empty) begin
                     rd_en_d = 1'b1;
                     done_d  = 1'b1;
                     bit_d   = BIT_LD;
                     ld_d    = 2'd1;
                  end else begin
                     state_d = S_HOLD;
                     cnt_d   = HOLD_LD;
                  end
`else
                  state_d = S_HOLD;
                  cnt_d   = HOLD_LD;
`endif
               end
            end
         end
         S_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef SPI_MASTER_TX_BURST_EN
      // Burst load lands two cycles after the chaining fall, once rd_data is valid.
      if (ld_q == 2'd1) begin
         ld_d = 2'd2;
      end else if (ld_q == 2'd2) begin
         shreg_d = bus.rd_data;
         mosi_d  = bus.rd_data[DATA_W-1];
         ld_d    = 2'd0;
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   assign bus.rd_en = rd_en_q;
   assign bus.sclk  = sclk_q;
   assign bus.cs_n  = cs_n_q;
   assign bus.mosi  = mosi_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
